// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and clamp helper
// Purpose : common definitions for the bcd_counter slice.
// Contents: bcd_digit_t (one packed BCD digit), BCD_MAX / BCD_MIN limits,
//           bcd_clamp() which saturates a nibble to a legal decimal digit.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit of the ripple carry/borrow chain
// Purpose : a single decimal digit register with clear, clamped load and step.
// Optional: BCD_COUNTER_DOWN_EN adds dir (1 = decrement, 0 = increment).
// Ports   : clk, rst (async, active-high), clr, load, load_d (raw nibble),
//           step_in (advance this digit), [dir], q (digit value 0..9),
//           step_out (this digit wraps on the current step -> next digit's step_in).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step_in,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       dir,
`endif
  output bcd_digit_t q,
  output logic       step_out
);

  logic       wrap;
  bcd_digit_t q_next;

`ifdef BCD_COUNTER_DOWN_EN
  always_comb begin
    wrap   = dir ? (q == BCD_MIN) : (q == BCD_MAX);
    q_next = BCD_MIN;
    if (dir) q_next = wrap ? BCD_MAX : q - 4'd1;
    else     q_next = wrap ? BCD_MIN : q + 4'd1;
  end
`else
  always_comb begin
    wrap   = (q == BCD_MAX);
    q_next = wrap ? BCD_MIN : q + 4'd1;
  end
`endif

  // The top only asserts step_in on a real step, so a wrap here is a carry.
  assign step_out = step_in && wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q <= BCD_MIN;
    else if (clr)     q <= BCD_MIN;
    else if (load)    q <= bcd_clamp(load_d);
    else if (step_in) q <= q_next;
  end

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD counter with built-in prescaler
// Purpose : steps a DIGITS-digit decimal count once every PRESCALE enabled
//           clocks; synchronous clear (highest priority) and clamped parallel
//           load (drops a coincident step); flags each step and each wrap.
// Optional: BCD_COUNTER_DOWN_EN adds input dir after load_val (1 = count down).
// Ports   : clk, rst (async, active-high), en, clr, load, load_val[4*DIGITS],
//           [dir], bcd[4*DIGITS] (digit 0 in bits 3:0), tick (new count
//           visible this cycle), ovf (that step wrapped past all-9 / all-0).
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                  dir,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  ovf
);

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   pcnt;
  logic            tc;
  logic            step;
  logic [DIGITS:0] carry;

  assign tc       = en && (pcnt == PCNT_LAST);
  // clr and load both outrank the step, so a terminal count under either is lost.
  assign step     = tc && !clr && !load;
  assign carry[0] = step;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .load_d   (load_val[4*k +: 4]),
      .step_in  (carry[k]),
`ifdef BCD_COUNTER_DOWN_EN
      .dir      (dir),
`endif
      .q        (bcd[4*k +: 4]),
      .step_out (carry[k+1])
    );
  end

  // Prescaler keeps running through a load; only clr restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pcnt <= '0;
    else if (clr)    pcnt <= '0;
    else if (en)     pcnt <= tc ? '0 : pcnt + 1'b1;
  end

  // Registered alongside the digits so tick/ovf line up with the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tick <= step;
      ovf  <= carry[DIGITS];
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - self-checking bench for bcd_counter
module tb_bcd_counter;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int W        = 4 * DIGITS;
  localparam int MODV     = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bcd;
  logic         tick, ovf;

  logic         en1 = 1'b0, clr1 = 1'b0, load1 = 1'b0, dir1 = 1'b0;
  logic [W-1:0] load_val1 = '0;
  logic [W-1:0] bcd1;
  logic         tick1, ovf1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef BCD_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .bcd(bcd), .tick(tick), .ovf(ovf)
  );

  bcd_counter #(.DIGITS(DIGITS), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .clr(clr1), .load(load1), .load_val(load_val1),
`ifdef BCD_COUNTER_DOWN_EN
    .dir(dir1),
`endif
    .bcd(bcd1), .tick(tick1), .ovf(ovf1)
  );

  // Reference model: count kept as a plain integer 0..99.
  function automatic int bus_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      int d = int'(v[4*k +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bus(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  logic m_down;
`ifdef BCD_COUNTER_DOWN_EN
  assign m_down = dir;
`else
  assign m_down = 1'b0;
`endif

  int   m_val, m_p;
  logic m_tick, m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val <= 0; m_p <= 0; m_tick <= 1'b0; m_ovf <= 1'b0;
    end else if (clr) begin
      m_val <= 0; m_p <= 0; m_tick <= 1'b0; m_ovf <= 1'b0;
    end else begin
      if (en) m_p <= (m_p + 1) % PRESCALE;
      if (load) begin
        m_val <= bus_to_int(load_val); m_tick <= 1'b0; m_ovf <= 1'b0;
      end else if (en && m_p == PRESCALE - 1) begin
        m_tick <= 1'b1;
        if (m_down) begin
          m_val <= (m_val + MODV - 1) % MODV; m_ovf <= (m_val == 0);
        end else begin
          m_val <= (m_val + 1) % MODV;        m_ovf <= (m_val == MODV - 1);
        end
      end else begin
        m_tick <= 1'b0; m_ovf <= 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    checks++;
    if (bcd !== 8'h00 || tick !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state bcd=%h tick=%b ovf=%b required bcd=00 tick=0 ovf=0", bcd, tick, ovf);
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (tick !== 1'b0 || bcd !== 8'h00) begin
        failures++;
        $display("FAIL reset_early_tick cycle=%0d bcd=%h tick=%b required bcd=00 tick=0", c, bcd, tick);
      end
    end
    @(negedge clk);
    checks++;
    if (tick !== 1'b1 || bcd !== 8'h01) begin
      failures++;
      $display("FAIL reset_first_tick bcd=%h tick=%b required bcd=01 tick=1", bcd, tick);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (tick !== (c == 4)) begin
        failures++;
        $display("FAIL reset_tick_period cycle=%0d tick=%b required %b", c, tick, (c == 4));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      clr      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      dir      = $urandom_range(0, 1) == 1;
      @(negedge clk);
      checks++;
      if (bcd !== int_to_bus(m_val) || tick !== m_tick || ovf !== m_ovf) begin
        failures++;
        $display("FAIL random i=%0d bcd=%h tick=%b ovf=%b required bcd=%h tick=%b ovf=%b",
                 i, bcd, tick, ovf, int_to_bus(m_val), m_tick, m_ovf);
      end
      for (int k = 0; k < DIGITS; k++) begin
        checks++;
        if (bcd[4*k +: 4] > 4'd9) begin
          failures++;
          $display("FAIL digit_range i=%0d digit%0d=%0d required <=9", i, k, bcd[4*k +: 4]);
        end
      end
    end
    en = 1'b1; clr = 1'b0; load = 1'b0; dir = 1'b0;
  endtask

  task automatic test_carry();
    int n;
    logic [W-1:0] vals [2] = '{8'h09, 8'h99};
    logic [W-1:0] exps [2] = '{8'h10, 8'h00};
    en = 1'b1; dir = 1'b0;
    for (int j = 0; j < 2; j++) begin
      load = 1'b1; load_val = vals[j];
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (tick !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (tick !== 1'b1 || bcd !== exps[j] || ovf !== (j == 1)) begin
        failures++;
        $display("FAIL carry_%0d bcd=%h tick=%b ovf=%b required bcd=%h tick=1 ovf=%b",
                 j, bcd, tick, ovf, exps[j], (j == 1));
      end
    end
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL ovf_one_cycle tick=%b ovf=%b required tick=0 ovf=0", tick, ovf);
    end
  endtask

  task automatic test_priority();
    int n;
    en = 1'b1;
    n = 0;
    while (m_p != PRESCALE - 1 && n < 10) begin @(negedge clk); n++; end
    clr = 1'b1; load = 1'b1; load_val = 8'h42;
    @(negedge clk);
    clr = 1'b0; load = 1'b0;
    checks++;
    if (bcd !== 8'h00 || tick !== 1'b0) begin
      failures++;
      $display("FAIL prio_clr bcd=%h tick=%b required bcd=00 tick=0", bcd, tick);
    end
    n = 0;
    while (m_p != PRESCALE - 1 && n < 10) begin @(negedge clk); n++; end
    load = 1'b1; load_val = 8'h42;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (bcd !== 8'h42 || tick !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL prio_load bcd=%h tick=%b ovf=%b required bcd=42 tick=0 ovf=0", bcd, tick, ovf);
    end
    en = 1'b0; load = 1'b1; load_val = 8'hAF;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (bcd !== 8'h99) begin
      failures++;
      $display("FAIL load_clamp bcd=%h required 99", bcd);
    end
  endtask

  task automatic test_freeze();
    int n;
    logic [W-1:0] held;
    en = 1'b1;
    n = 0;
    while (tick !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    held = bcd;
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bcd !== held || tick !== 1'b0) begin
        failures++;
        $display("FAIL freeze c=%0d bcd=%h tick=%b required bcd=%h tick=0", c, bcd, tick, held);
      end
    end
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 10);
    checks++;
    if (n != PRESCALE - 2 || bcd !== int_to_bus((bus_to_int(held) + 1) % MODV)) begin
      failures++;
      $display("FAIL freeze_resume cycles=%0d bcd=%h required cycles=%0d bcd=%h",
               n, bcd, PRESCALE - 2, int_to_bus((bus_to_int(held) + 1) % MODV));
    end
  endtask

  task automatic test_async_rst();
    en = 1'b0; load = 1'b1; load_val = 8'h57;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (bcd !== 8'h57) begin
      failures++;
      $display("FAIL async_pre bcd=%h required 57", bcd);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bcd !== 8'h00 || tick !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_rst bcd=%h tick=%b ovf=%b required bcd=00 tick=0 ovf=0", bcd, tick, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_prescale1();
    int v;
    logic wrapped;
`ifdef BCD_COUNTER_DOWN_EN
    v = 1; dir1 = 1'b1;
`else
    v = 98; dir1 = 1'b0;
`endif
    en1 = 1'b0; load1 = 1'b1; load_val1 = int_to_bus(v);
    @(negedge clk);
    load1 = 1'b0; en1 = 1'b1;
    checks++;
    if (bcd1 !== int_to_bus(v)) begin
      failures++;
      $display("FAIL p1_load bcd=%h required %h", bcd1, int_to_bus(v));
    end
    for (int c = 0; c < 5; c++) begin
      if (dir1) begin wrapped = (v == 0);        v = (v + MODV - 1) % MODV; end
      else      begin wrapped = (v == MODV - 1); v = (v + 1) % MODV;        end
      @(negedge clk);
      checks++;
      if (bcd1 !== int_to_bus(v) || tick1 !== 1'b1 || ovf1 !== wrapped) begin
        failures++;
        $display("FAIL p1_step c=%0d bcd=%h tick=%b ovf=%b required bcd=%h tick=1 ovf=%b",
                 c, bcd1, tick1, ovf1, int_to_bus(v), wrapped);
      end
    end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_random();
    test_carry();
    test_priority();
    test_freeze();
    test_async_rst();
    test_prescale1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
